// File: rtl/top.sv
// Registered barrel rotator: OUT loads IN rotated left by SHIFT on each clock.
// The rotate network has one stage per SHIFT bit; only the final result is registered.
module top #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   IN,
    input  logic [SHIFT_W-1:0] SHIFT,
    output logic [WIDTH-1:0]   OUT
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Upper half of the doubled word shifted left is the circular rotate by 2^k.
    function automatic logic [WIDTH-1:0] rot_pow2(input logic [WIDTH-1:0] x, input int k);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} << (1 << k);
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    always_comb begin
        out_d = IN;
        for (int k = 0; k < SHIFT_W; k++) begin
            if (SHIFT[k]) begin
                out_d = rot_pow2(out_d, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the registered barrel rotator: directed table,
// reset sequences, back-to-back random stream and an exhaustive sweep.
module tb_top;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_w;
    logic [2:0] shift_w;
    logic [7:0] out_w;

    int n_cmp;
    int n_bad;

    top #(.WIDTH(8), .SHIFT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .IN    (in_w),
        .SHIFT (shift_w),
        .OUT   (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [2:0] sh;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Reference: bit i of result comes from input bit (i - sh) mod 8.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input int sh);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[(i - sh + 8) % 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, let one edge pass, sample 1 time unit after it.
    task automatic step(input logic [7:0] d, input logic [2:0] s);
        in_w    = d;
        shift_w = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{8'b00010001, 3'd0, 8'b00010001};
        vecs[1] = '{8'b00010001, 3'd1, 8'b00100010};
        vecs[2] = '{8'b00010001, 3'd2, 8'b01000100};
        vecs[3] = '{8'b00010001, 3'd3, 8'b10001000};
        vecs[4] = '{8'b00010001, 3'd4, 8'b00010001};
        vecs[5] = '{8'b00010001, 3'd5, 8'b00100010};
        vecs[6] = '{8'b00010001, 3'd6, 8'b01000100};
        vecs[7] = '{8'b00010001, 3'd7, 8'b10001000};
        vecs[8] = '{8'b10000001, 3'd1, 8'b00000011};
        vecs[9] = '{8'b10110000, 3'd7, 8'b01011000};

        // Reset held with active-looking inputs: OUT must stay zero.
        rst_n   = 1'b0;
        in_w    = 8'hFF;
        shift_w = 3'd3;
        #2;
        check("reset_async", out_w, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", out_w, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", out_w, 8'hFF);

        foreach (vecs[i]) begin
            step(vecs[i].din, vecs[i].sh);
            check($sformatf("vec%0d", i), out_w, vecs[i].exp);
        end

        // Inputs changing between edges must not disturb OUT.
        step(8'h11, 3'd3);
        check("pre_stable", out_w, 8'h88);
        in_w    = 8'hA5;
        shift_w = 3'd5;
        #3;
        check("between_edges", out_w, 8'h88);

        // Mid-stream async reset while OUT = 88.
        rst_n = 1'b0;
        #1;
        check("midstream_clear", out_w, 8'h00);
        @(posedge clk);
        #1;
        check("midstream_hold", out_w, 8'h00);
        #2;
        in_w    = 8'b10000001;
        shift_w = 3'd1;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("midstream_release", out_w, 8'h03);

        // Back-to-back random stream, new pair every cycle.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            logic [2:0] s;
            d = 8'($urandom_range(0, 255));
            s = 3'($urandom_range(0, 7));
            step(d, s);
            check("random", out_w, ref_rot(d, int'(s)));
        end

        // Exhaustive sweep.
        for (int d = 0; d < 256; d++) begin
            for (int s = 0; s < 8; s++) begin
                step(8'(d), 3'(s));
                check("exhaustive", out_w, ref_rot(8'(d), s));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
